sccb_target: RTL and testbench
==============================

Name: sccb_target

Overview:
- SCCB responder (camera-side end of the bus); the counterpart of the SCCB initiator block.
- Oversamples the sioc/siod lines with the fast system clock.
- Decodes 3-phase writes, and 2-phase write followed by 2-phase read.
- Exposes a simple register-bus port so a register file or OV-camera model can sit behind it on the FPGA for closed-loop bring-up of the initiator.

Parameters:
- DEV_ID, 7'h21, 7-bit device ID this target answers to (write byte 0x42, read byte 0x43).
- SYNC_STAGES, 2, synchronizer flops on sioc_in and siod_in (legal range 2..3).

Ports:
- clk  in  1  system clock; must be >= 8x the SIOC frequency.
- resetn  in  1  reset.
- sioc_in  in  1  SCCB clock from initiator (pulled high when idle).
- siod_in  in  1  SCCB data line as seen at pad.
- siod_o  out  1  data value to drive.
- siod_oe  out  1  1 = drive siod_o onto pad, 0 = release (top level tri-states).
- reg_addr  out  8  latched sub-address.
- reg_wdata  out  8  write data.
- reg_we  out  1  one-clk write strobe.
- reg_re  out  1  one-clk read request.
- reg_rdata  in  8  read data, valid 1 clk after reg_re.
- busy  out  1  high from accepted START until STOP.

Interface: one clock (clk); reset (resetn) is asynchronous and active-low.

Behaviour:
- Reset values: all registers cleared; state IDLE; siod_o=1; siod_oe=0; reg_addr=0; reg_wdata=0; reg_we=0; reg_re=0; busy=0.
- Synchronizers reset to 1.
- Line events, evaluated on synced lines:
  - START: siod falls while sioc=1.
  - STOP: siod rises while sioc=1.
  - RISE / FALL: sioc edge.
  - Bits are sampled on RISE; target-driven bits change on FALL.
- Bit counter counts 7 down to 0, MSB first.
- FSM states: IDLE, ID, ID_DC, SUB, SUB_DC, WDATA, WDATA_DC, RDATA, RDATA_NA, WAIT_STOP.
- START from any state: go to ID, counter=7, busy=1, siod_oe=0. This covers repeated start.
- STOP from any state: go to IDLE, busy=0, siod_oe=0.
- ID: shift 8 bits (7 ID bits + R/W). After 8th RISE:
  - ID != DEV_ID: go to WAIT_STOP (ignore all traffic until STOP/START).
  - ID match, R/W=0: go to ID_DC.
  - ID match, R/W=1: pulse reg_re in the next clk, capture reg_rdata into shift register 1 clk later, go to ID_DC.
- ID_DC: 9th bit consumed on RISE.
  - Next state: SUB if write, RDATA if read.
- SUB: after 8th RISE latch reg_addr, go to SUB_DC.
- SUB_DC: 9th RISE, then go to WDATA. A STOP here ends a 2-phase write; reg_addr is kept for the following read.
- WDATA: after 8th RISE, reg_wdata <= byte, then go to WDATA_DC.
- WDATA_DC: reg_we pulses exactly 1 clk on the 9th RISE. Then go to WAIT_STOP; extra bytes are ignored, no auto-increment.
- RDATA:
  - FALL ending the ID_DC bit: siod_oe=1, siod_o=bit7.
  - Each subsequent FALL presents the next bit.
  - After bit0's RISE, the next FALL sets siod_oe=0; go to RDATA_NA.
- RDATA_NA: initiator's NA bit sampled and ignored; go to WAIT_STOP.
- siod_oe is never high outside RDATA, apart from the optional feature below.
- If START/STOP arrives in the same clk as RISE: START/STOP wins; the bit is discarded.
- reg_addr persists across transactions and is changed only by SUB.
- Async reset mid-transfer: siod_oe drops immediately (same edge). No reg_we is issued for a partial byte.

Optional Feature:
- Macro SCCB_TARGET_ACK_EN.
- Defined: during ID_DC (ID match only), SUB_DC and WDATA_DC, the target drives siod_o=0, siod_oe=1.
  - Driven from the FALL that starts the 9th bit to the FALL that ends it.
  - Gives I2C-style ACK visibility on a scope.
- Undefined: the line is released during all don't-care bits. This is SCCB-strict; the pull-up reads 1.

Test Plan:
- 3-phase write, ID 0x21, sub 0x12, data 0x80 -> exactly one reg_we pulse with reg_addr=0x12 and reg_wdata=0x80; siod_oe stays 0 (macro off); busy 1 from START to STOP.
- 2-phase write sub 0x0A, STOP, then 2-phase read with reg_rdata=0x5A -> one reg_re pulse; siod sampled on 8 RISEs = 0,1,0,1,1,0,1,0; siod_oe=0 at NA bit; reg_addr=0x0A.
- Write to ID 0x30 -> no reg_we/reg_re; siod_oe never asserted; busy drops at STOP.
- Repeated START after SUB byte (no STOP), then a read -> read returns data for the new latched sub-address; the first transaction produces no reg_we.
- Assert resetn low mid-RDATA (bit 4) -> siod_oe=0 and busy=0 asynchronously; the next full 3-phase write completes normally.
- With SCCB_TARGET_ACK_EN defined, 3-phase write -> siod driven 0 for all three 9th bits; with ID 0x30 the ID_DC bit is not driven.

Source files
------------

// File: rtl/sccb_target_if.sv
// Register-bus port of the SCCB target: the target (master) issues address, data and
// strobes; a register file or camera model (slave) returns read data one clk after reg_re.
interface sccb_target_if;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;

   modport master (output reg_addr, output reg_wdata, output reg_we, output reg_re,
                   input  reg_rdata);
   modport slave  (input  reg_addr, input  reg_wdata, input  reg_we, input  reg_re,
                   output reg_rdata);
endinterface

// File: rtl/sccb_target.sv
// SCCB responder: oversamples sioc/siod, decodes 3-phase writes and 2-phase write/read pairs.
// Optional macro SCCB_TARGET_ACK_EN drives an I2C-style 0 on the don't-care (9th) bits.
module sccb_target #(
   parameter logic [6:0] DEV_ID      = 7'h21,
   parameter int         SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          sioc_in,
   input  logic          siod_in,
   output logic          siod_o,
   output logic          siod_oe,
   output logic          busy,
   sccb_target_if.master rb
);

`ifdef SCCB_TARGET_ACK_EN
   localparam logic ACK_EN = 1'b1;
`else
   localparam logic ACK_EN = 1'b0;
`endif

   typedef enum logic [3:0] {
      IDLE, ID, ID_DC, SUB, SUB_DC, WDATA, WDATA_DC, RDATA, RDATA_NA, WAIT_STOP
   } state_t;

   logic [SYNC_STAGES-1:0] sioc_sync_q, sioc_sync_d;
   logic [SYNC_STAGES-1:0] siod_sync_q, siod_sync_d;
   logic                   sioc_prev_q, sioc_prev_d;
   logic                   siod_prev_q, siod_prev_d;
   state_t                 state_q, state_d;
   logic [2:0]             cnt_q, cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   rw_q, rw_d;
   logic                   rd_done_q, rd_done_d;
   logic                   load_q, load_d;
   logic                   siod_o_q, siod_o_d;
   logic                   siod_oe_q, siod_oe_d;
   logic                   busy_q, busy_d;
   logic [7:0]             reg_addr_q, reg_addr_d;
   logic [7:0]             reg_wdata_q, reg_wdata_d;
   logic                   reg_we_q, reg_we_d;
   logic                   reg_re_q, reg_re_d;

   logic       sioc_s, siod_s;
   logic       ev_rise, ev_fall, ev_start, ev_stop;
   logic [7:0] byte_in;

   assign sioc_s = sioc_sync_q[SYNC_STAGES-1];
   assign siod_s = siod_sync_q[SYNC_STAGES-1];

   // Only sioc=1 is required for START/STOP, so they pre-empt a RISE seen in the same clk.
   assign ev_rise  = sioc_s & ~sioc_prev_q;
   assign ev_fall  = ~sioc_s & sioc_prev_q;
   assign ev_start = sioc_s & siod_prev_q & ~siod_s;
   assign ev_stop  = sioc_s & ~siod_prev_q & siod_s;
   assign byte_in  = {shift_q[6:0], siod_s};

   always_comb begin
      sioc_sync_d = {sioc_sync_q[SYNC_STAGES-2:0], sioc_in};
      siod_sync_d = {siod_sync_q[SYNC_STAGES-2:0], siod_in};
      sioc_prev_d = sioc_s;
      siod_prev_d = siod_s;
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      rw_d        = rw_q;
      rd_done_d   = rd_done_q;
      load_d      = reg_re_q;
      siod_o_d    = siod_o_q;
      siod_oe_d   = siod_oe_q;
      busy_d      = busy_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_we_d    = 1'b0;
      reg_re_d    = 1'b0;

      // Read data is captured one clk after the reg_re pulse.
      if (load_q) begin
         shift_d = rb.reg_rdata;
      end

      if (ev_start) begin
         state_d   = ID;
         cnt_d     = 3'd7;
         busy_d    = 1'b1;
         siod_oe_d = 1'b0;
         siod_o_d  = 1'b1;
         rd_done_d = 1'b0;
      end else if (ev_stop) begin
         state_d   = IDLE;
         busy_d    = 1'b0;
         siod_oe_d = 1'b0;
         siod_o_d  = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: ;
            ID: begin
               if (ev_rise) begin
                  shift_d = byte_in;
                  if (cnt_q == 3'd0) begin
                     if (byte_in[7:1] != DEV_ID) begin
                        state_d = WAIT_STOP;
                     end else begin
                        rw_d     = byte_in[0];
                        reg_re_d = byte_in[0];
                        state_d  = ID_DC;
                     end
                  end else begin
                     cnt_d = cnt_q - 3'd1;
                  end
               end
            end
            ID_DC: begin
               if (ev_fall) begin
                  siod_oe_d = ACK_EN;
                  siod_o_d  = ~ACK_EN;
               end else if (ev_rise) begin
                  cnt_d   = 3'd7;
                  state_d = rw_q ? RDATA : SUB;
               end
            end
            SUB: begin
               if (ev_fall) begin
                  siod_oe_d = 1'b0;
                  siod_o_d  = 1'b1;
               end else if (ev_rise) begin
                  shift_d = byte_in;
                  if (cnt_q == 3'd0) begin
                     reg_addr_d = byte_in;
                     state_d    = SUB_DC;
                  end else begin
                     cnt_d = cnt_q - 3'd1;
                  end
               end
            end
            SUB_DC: begin
               if (ev_fall) begin
                  siod_oe_d = ACK_EN;
                  siod_o_d  = ~ACK_EN;
               end else if (ev_rise) begin
                  cnt_d   = 3'd7;
                  state_d = WDATA;
               end
            end
            WDATA: begin
               if (ev_fall) begin
                  siod_oe_d = 1'b0;
                  siod_o_d  = 1'b1;
               end else if (ev_rise) begin
                  shift_d = byte_in;
                  if (cnt_q == 3'd0) begin
                     reg_wdata_d = byte_in;
                     state_d     = WDATA_DC;
                  end else begin
                     cnt_d = cnt_q - 3'd1;
                  end
               end
            end
            WDATA_DC: begin
               if (ev_fall) begin
                  siod_oe_d = ACK_EN;
                  siod_o_d  = ~ACK_EN;
               end else if (ev_rise) begin
                  reg_we_d = 1'b1;
                  state_d  = WAIT_STOP;
               end
            end
            RDATA: begin
               // Each FALL presents shift_q[7]; the FALL after bit0's RISE releases the line.
               if (ev_fall) begin
                  if (rd_done_q) begin
                     siod_oe_d = 1'b0;
                     siod_o_d  = 1'b1;
                     state_d   = RDATA_NA;
                  end else begin
                     siod_oe_d = 1'b1;
                     siod_o_d  = shift_q[7];
                  end
               end else if (ev_rise) begin
                  shift_d = {shift_q[6:0], 1'b0};
                  if (cnt_q == 3'd0) begin
                     rd_done_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q - 3'd1;
                  end
               end
            end
            RDATA_NA: begin
               if (ev_rise) begin
                  state_d = WAIT_STOP;
               end
            end
            WAIT_STOP: begin
               if (ev_fall) begin
                  siod_oe_d = 1'b0;
                  siod_o_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sioc_sync_q <= '1;
         siod_sync_q <= '1;
         sioc_prev_q <= 1'b1;
         siod_prev_q <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         shift_q     <= 8'd0;
         rw_q        <= 1'b0;
         rd_done_q   <= 1'b0;
         load_q      <= 1'b0;
         siod_o_q    <= 1'b1;
         siod_oe_q   <= 1'b0;
         busy_q      <= 1'b0;
         reg_addr_q  <= 8'd0;
         reg_wdata_q <= 8'd0;
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
      end else begin
         sioc_sync_q <= sioc_sync_d;
         siod_sync_q <= siod_sync_d;
         sioc_prev_q <= sioc_prev_d;
         siod_prev_q <= siod_prev_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         rw_q        <= rw_d;
         rd_done_q   <= rd_done_d;
         load_q      <= load_d;
         siod_o_q    <= siod_o_d;
         siod_oe_q   <= siod_oe_d;
         busy_q      <= busy_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_we_q    <= reg_we_d;
         reg_re_q    <= reg_re_d;
      end
   end

   assign siod_o       = siod_o_q;
   assign siod_oe      = siod_oe_q;
   assign busy         = busy_q;
   assign rb.reg_addr  = reg_addr_q;
   assign rb.reg_wdata = reg_wdata_q;
   assign rb.reg_we    = reg_we_q;
   assign rb.reg_re    = reg_re_q;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: a bit-banged SCCB initiator, a read-only register file, and a
// transaction-level model (latched sub-address + register contents) predicting the results.
module tb_sccb_target;
   localparam int Q = 4;
`ifdef SCCB_TARGET_ACK_EN
   localparam logic ACK_EXP = 1'b1;
`else
   localparam logic ACK_EXP = 1'b0;
`endif
   localparam logic [7:0] WR_ID = 8'h42;
   localparam logic [7:0] RD_ID = 8'h43;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic sioc_drv = 1'b1;
   logic siod_drv = 1'b1;
   logic siod_o, siod_oe, busy, siod_line;

   int total = 0;
   int bad = 0;
   int we_cnt = 0;
   int re_cnt = 0;
   int oe_cnt = 0;
   logic [7:0] last_we_addr = 8'h00;
   logic [7:0] last_we_data = 8'h00;
   logic [7:0] mem [256];
   logic [7:0] ref_addr;

   always #5 clk = ~clk;

   // Open-drain pad: either side can pull low, pull-up otherwise.
   assign siod_line = siod_drv & (siod_oe ? siod_o : 1'b1);

   sccb_target_if bus();

   sccb_target #(.DEV_ID(7'h21), .SYNC_STAGES(2)) dut (
      .clk(clk), .resetn(resetn), .sioc_in(sioc_drv), .siod_in(siod_line),
      .siod_o(siod_o), .siod_oe(siod_oe), .busy(busy), .rb(bus)
   );

   always @(posedge clk) begin
      if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
   end

   always @(negedge clk) begin
      if (bus.reg_we) begin
         we_cnt++;
         last_we_addr = bus.reg_addr;
         last_we_data = bus.reg_wdata;
      end
      if (bus.reg_re) re_cnt++;
      if (siod_oe) oe_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_start();
      siod_drv = 1'b1; tick(Q);
      sioc_drv = 1'b1; tick(Q);
      siod_drv = 1'b0; tick(Q);
      sioc_drv = 1'b0; tick(Q);
   endtask

   task automatic bus_stop();
      siod_drv = 1'b0; tick(Q);
      sioc_drv = 1'b1; tick(Q);
      siod_drv = 1'b1; tick(2 * Q);
   endtask

   task automatic bus_bit(input logic b, output logic smp, output logic oe_smp);
      siod_drv = b;    tick(Q);
      sioc_drv = 1'b1; tick(Q);
      smp = siod_line;
      oe_smp = siod_oe;
      tick(Q);
      sioc_drv = 1'b0; tick(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack_line, output logic ack_oe);
      logic s, o;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], s, o);
      bus_bit(1'b1, ack_line, ack_oe);
   endtask

   task automatic read_byte(output logic [7:0] d, output logic na_oe);
      logic s, o;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, s, o);
         d[i] = s;
      end
      bus_bit(1'b1, s, na_oe);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick(3);
      total++; if (siod_o !== 1'b1) begin bad++; $display("FAIL rst_siod_o got=%b exp=1", siod_o); end
      total++; if (siod_oe !== 1'b0) begin bad++; $display("FAIL rst_siod_oe got=%b exp=0", siod_oe); end
      total++; if (bus.reg_addr !== 8'h00) begin bad++; $display("FAIL rst_reg_addr got=%h exp=00", bus.reg_addr); end
      total++; if (bus.reg_wdata !== 8'h00) begin bad++; $display("FAIL rst_reg_wdata got=%h exp=00", bus.reg_wdata); end
      total++; if (bus.reg_we !== 1'b0) begin bad++; $display("FAIL rst_reg_we got=%b exp=0", bus.reg_we); end
      total++; if (bus.reg_re !== 1'b0) begin bad++; $display("FAIL rst_reg_re got=%b exp=0", bus.reg_re); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      resetn = 1'b1;
      ref_addr = 8'h00;
      tick(4);
   endtask

   task automatic test_write3();
      int we0 = we_cnt;
      int oe0 = oe_cnt;
      logic a0, o0, a1, o1, a2, o2;
      bus_start();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL w3_busy_start got=%b exp=1", busy); end
      send_byte(WR_ID, a0, o0);
      send_byte(8'h12, a1, o1);
      send_byte(8'h80, a2, o2);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL w3_busy_mid got=%b exp=1", busy); end
      bus_stop();
      ref_addr = 8'h12;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL w3_busy_stop got=%b exp=0", busy); end
      total++; if (we_cnt - we0 != 1) begin bad++; $display("FAIL w3_we_pulses got=%0d exp=1", we_cnt - we0); end
      total++; if (last_we_addr !== 8'h12) begin bad++; $display("FAIL w3_we_addr got=%h exp=12", last_we_addr); end
      total++; if (last_we_data !== 8'h80) begin bad++; $display("FAIL w3_we_data got=%h exp=80", last_we_data); end
      total++; if ({o0, o1, o2} !== {3{ACK_EXP}}) begin bad++; $display("FAIL w3_ack_oe got=%b exp=%b", {o0, o1, o2}, {3{ACK_EXP}}); end
      total++; if ({a0, a1, a2} !== {3{~ACK_EXP}}) begin bad++; $display("FAIL w3_ack_line got=%b exp=%b", {a0, a1, a2}, {3{~ACK_EXP}}); end
      total++; if ((oe_cnt != oe0) !== ACK_EXP) begin bad++; $display("FAIL w3_oe_seen got=%b exp=%b", oe_cnt != oe0, ACK_EXP); end
      total++; if (bus.reg_addr !== 8'h12) begin bad++; $display("FAIL w3_reg_addr got=%h exp=12", bus.reg_addr); end
   endtask

   task automatic test_write_read();
      int we0 = we_cnt;
      int re0;
      logic a, o, na_oe;
      logic [7:0] d;
      bus_start();
      send_byte(WR_ID, a, o);
      send_byte(8'h0A, a, o);
      bus_stop();
      ref_addr = 8'h0A;
      re0 = re_cnt;
      bus_start();
      send_byte(RD_ID, a, o);
      read_byte(d, na_oe);
      bus_stop();
      total++; if (we_cnt - we0 != 0) begin bad++; $display("FAIL wr_no_we got=%0d exp=0", we_cnt - we0); end
      total++; if (re_cnt - re0 != 1) begin bad++; $display("FAIL wr_re_pulses got=%0d exp=1", re_cnt - re0); end
      total++; if (d !== 8'h5A) begin bad++; $display("FAIL wr_rdata got=%b exp=01011010", d); end
      total++; if (na_oe !== 1'b0) begin bad++; $display("FAIL wr_na_oe got=%b exp=0", na_oe); end
      total++; if (bus.reg_addr !== ref_addr) begin bad++; $display("FAIL wr_reg_addr got=%h exp=%h", bus.reg_addr, ref_addr); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy got=%b exp=0", busy); end
   endtask

   task automatic test_wrong_id();
      int we0 = we_cnt;
      int re0 = re_cnt;
      int oe0 = oe_cnt;
      logic a0, o0, a, o;
      bus_start();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL wid_busy_start got=%b exp=1", busy); end
      send_byte(8'h60, a0, o0);
      send_byte(8'h33, a, o);
      send_byte(8'h44, a, o);
      bus_stop();
      total++; if (o0 !== 1'b0) begin bad++; $display("FAIL wid_id_ack_oe got=%b exp=0", o0); end
      total++; if (we_cnt - we0 != 0) begin bad++; $display("FAIL wid_we got=%0d exp=0", we_cnt - we0); end
      total++; if (re_cnt - re0 != 0) begin bad++; $display("FAIL wid_re got=%0d exp=0", re_cnt - re0); end
      total++; if (oe_cnt - oe0 != 0) begin bad++; $display("FAIL wid_oe got=%0d exp=0", oe_cnt - oe0); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wid_busy_stop got=%b exp=0", busy); end
      total++; if (bus.reg_addr !== ref_addr) begin bad++; $display("FAIL wid_reg_addr got=%h exp=%h", bus.reg_addr, ref_addr); end
   endtask

   task automatic test_repeated_start();
      int we0 = we_cnt;
      int re0 = re_cnt;
      logic a, o, na_oe;
      logic [7:0] d;
      logic [7:0] sub = 8'($urandom);
      bus_start();
      send_byte(WR_ID, a, o);
      send_byte(sub, a, o);
      bus_start();
      send_byte(RD_ID, a, o);
      read_byte(d, na_oe);
      bus_stop();
      ref_addr = sub;
      total++; if (we_cnt - we0 != 0) begin bad++; $display("FAIL rs_we got=%0d exp=0", we_cnt - we0); end
      total++; if (re_cnt - re0 != 1) begin bad++; $display("FAIL rs_re got=%0d exp=1", re_cnt - re0); end
      total++; if (d !== mem[ref_addr]) begin bad++; $display("FAIL rs_rdata got=%h exp=%h", d, mem[ref_addr]); end
      total++; if (bus.reg_addr !== ref_addr) begin bad++; $display("FAIL rs_reg_addr got=%h exp=%h", bus.reg_addr, ref_addr); end
   endtask

   task automatic test_reset_mid_read();
      int we0;
      logic a, o, s;
      logic [7:0] sub = 8'($urandom);
      logic [7:0] dat = 8'($urandom);
      bus_start();
      send_byte(RD_ID, a, o);
      for (int i = 0; i < 3; i++) bus_bit(1'b1, s, o);
      siod_drv = 1'b1;
      tick(Q);
      total++; if (siod_oe !== 1'b1) begin bad++; $display("FAIL rmr_oe_bit4 got=%b exp=1", siod_oe); end
      @(negedge clk);
      resetn = 1'b0;
      #1;
      total++; if (siod_oe !== 1'b0) begin bad++; $display("FAIL rmr_async_oe got=%b exp=0", siod_oe); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmr_async_busy got=%b exp=0", busy); end
      tick(2);
      sioc_drv = 1'b1;
      siod_drv = 1'b1;
      tick(Q);
      resetn = 1'b1;
      ref_addr = 8'h00;
      tick(Q);
      total++; if (bus.reg_addr !== ref_addr) begin bad++; $display("FAIL rmr_reg_addr got=%h exp=%h", bus.reg_addr, ref_addr); end
      we0 = we_cnt;
      bus_start();
      send_byte(WR_ID, a, o);
      send_byte(sub, a, o);
      send_byte(dat, a, o);
      bus_stop();
      ref_addr = sub;
      total++; if (we_cnt - we0 != 1) begin bad++; $display("FAIL rmr_we got=%0d exp=1", we_cnt - we0); end
      total++; if ({last_we_addr, last_we_data} !== {sub, dat}) begin bad++; $display("FAIL rmr_we_val got=%h exp=%h", {last_we_addr, last_we_data}, {sub, dat}); end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 12; n++) begin
         int kind = $urandom_range(0, 3);
         int we0 = we_cnt;
         int re0 = re_cnt;
         logic a, o, na_oe;
         logic [7:0] d;
         logic [7:0] sub = 8'($urandom);
         logic [7:0] dat = 8'($urandom);
         logic [6:0] bad_id = 7'($urandom);
         if (bad_id == 7'h21) bad_id = 7'h22;
         bus_start();
         case (kind)
            0: begin
               send_byte(WR_ID, a, o);
               send_byte(sub, a, o);
               send_byte(dat, a, o);
               bus_stop();
               ref_addr = sub;
               total++; if (we_cnt - we0 != 1 || last_we_addr !== sub || last_we_data !== dat) begin
                  bad++; $display("FAIL b2b_write n=%0d got=%0d/%h/%h exp=1/%h/%h", n, we_cnt - we0, last_we_addr, last_we_data, sub, dat);
               end
            end
            1: begin
               send_byte(WR_ID, a, o);
               send_byte(sub, a, o);
               bus_stop();
               ref_addr = sub;
               bus_start();
               send_byte(RD_ID, a, o);
               read_byte(d, na_oe);
               bus_stop();
               total++; if (d !== mem[ref_addr] || re_cnt - re0 != 1 || we_cnt != we0) begin
                  bad++; $display("FAIL b2b_wr_rd n=%0d got=%h re=%0d exp=%h re=1", n, d, re_cnt - re0, mem[ref_addr]);
               end
            end
            2: begin
               send_byte({bad_id, dat[0]}, a, o);
               send_byte(sub, a, o);
               send_byte(dat, a, o);
               bus_stop();
               total++; if (we_cnt != we0 || re_cnt != re0 || bus.reg_addr !== ref_addr) begin
                  bad++; $display("FAIL b2b_bad_id n=%0d got=we%0d re%0d addr%h exp=0/0/%h", n, we_cnt - we0, re_cnt - re0, bus.reg_addr, ref_addr);
               end
            end
            default: begin
               send_byte(RD_ID, a, o);
               read_byte(d, na_oe);
               bus_stop();
               total++; if (d !== mem[ref_addr] || na_oe !== 1'b0) begin
                  bad++; $display("FAIL b2b_read n=%0d got=%h na_oe=%b exp=%h na_oe=0", n, d, na_oe, mem[ref_addr]);
               end
            end
         endcase
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy n=%0d got=%b exp=0", n, busy); end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h0A] = 8'h5A;
      test_reset();
      test_write3();
      test_write_read();
      test_wrong_id();
      test_repeated_start();
      test_reset_mid_read();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
